fetch_pc_queue: RTL and testbench

Parametrised program-counter and instruction-fetch queue for the RISC-V core. It generates the fetch address each cycle, captures the word returned by the combinational instruction memory (`imem`), and buffers {pc, instruction} pairs in a DEPTH-entry FIFO toward decode. It supports stall via backpressure, global enable and redirect (branch/jump/trap). It replaces the free-running PC counter in the fetch path.

---
 rtl/fetch_pc_queue.sv | 84 ++++++++
 tb/tb_fetch_pc_queue.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_queue.sv
// Fetch program counter and {pc, instr} FIFO toward decode.
// Redirect flushes the queue and reloads the PC. There is no empty-queue bypass.
module fetch_pc_queue #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              STEP         = 4,
  parameter int              DEPTH        = 4
) (
  input  logic                       Clk,
  input  logic                       reset,
  input  logic                       enable,
  output logic [XLEN-1:0]            imem_addr,
  input  logic [31:0]                imem_data,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_pc,
  output logic [31:0]                deq_instr,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] mem_pc    [DEPTH];
  logic [31:0]     mem_instr [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   cnt;
  logic            full;
  logic            empty;
  logic            do_enq;
  logic            do_deq;

  assign full   = (cnt == CW'(DEPTH));
  assign empty  = (cnt == '0);
  assign do_enq = !redirect && enable && !full;
  assign do_deq = !redirect && !empty && deq_ready;

  // Redirect wins over enqueue and dequeue in the same cycle.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      pc     <= RESET_VECTOR;
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (redirect) begin
      pc     <= redirect_pc & ~XLEN'(3);
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_enq) begin
        pc     <= pc + XLEN'(STEP);
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_deq) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({do_enq, do_deq})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (do_enq) begin
      mem_pc[wr_ptr]    <= pc;
      mem_instr[wr_ptr] <= imem_data;
    end
  end

  // Outputs are zeroed while empty so stale storage never leaks to decode.
  assign imem_addr = pc;
  assign deq_valid = !empty;
  assign deq_pc    = empty ? '0 : mem_pc[rd_ptr];
  assign deq_instr = empty ? '0 : mem_instr[rd_ptr];
  assign count     = cnt;

endmodule

// File: tb/tb_fetch_pc_queue.sv
// Bench for fetch_pc_queue: hand-computed vector table, corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_fetch_pc_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        reset;
  logic        enable, redirect, deq_ready;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_data, deq_pc, deq_instr;
  logic        deq_valid;
  logic [2:0]  count;

  logic        w_enable, w_deq_ready, w_deq_valid;
  logic [31:0] w_imem_addr, w_imem_data, w_deq_pc, w_deq_instr;
  logic [2:0]  w_count;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  fetch_pc_queue #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .STEP(4), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .reset(reset), .enable(enable), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_pc(deq_pc),
    .deq_instr(deq_instr), .count(count)
  );

  fetch_pc_queue #(.XLEN(XLEN), .RESET_VECTOR(32'hFFFF_FFF8), .STEP(4), .DEPTH(DEPTH)) u_wrap (
    .Clk(Clk), .reset(reset), .enable(w_enable), .imem_addr(w_imem_addr),
    .imem_data(w_imem_data), .redirect(1'b0), .redirect_pc(32'h0),
    .deq_valid(w_deq_valid), .deq_ready(w_deq_ready), .deq_pc(w_deq_pc),
    .deq_instr(w_deq_instr), .count(w_count)
  );

  function automatic logic [31:0] imem_fn(input logic [31:0] a);
    return 32'h1000 + (a >> 2);
  endfunction

  always_comb imem_data   = imem_fn(imem_addr);
  always_comb w_imem_data = w_imem_addr ^ 32'h5A5A_0000;

  // Reference model: a PC and a bounded queue of fetched words.
  logic [31:0] m_pc;
  logic [31:0] q_pc[$];
  logic [31:0] q_instr[$];

  task automatic model_reset(input logic [31:0] rv);
    m_pc = rv;
    q_pc.delete();
    q_instr.delete();
  endtask

  task automatic model_step(input logic en, input logic rdy, input logic redir,
                            input logic [31:0] rpc);
    bit enq, deq;
    if (redir) begin
      m_pc = {rpc[31:2], 2'b00};
      q_pc.delete();
      q_instr.delete();
    end else begin
      enq = en && (q_pc.size() < DEPTH);
      deq = rdy && (q_pc.size() > 0);
      if (deq) begin
        void'(q_pc.pop_front());
        void'(q_instr.pop_front());
      end
      if (enq) begin
        q_pc.push_back(m_pc);
        q_instr.push_back(imem_fn(m_pc));
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic compare_model(input string tag);
    int n;
    n = q_pc.size();
    check_output({tag, " count"}, 32'(count), 32'(n));
    check_output({tag, " valid"}, 32'(deq_valid), 32'(n > 0));
    check_output({tag, " deq_pc"}, deq_pc, (n > 0) ? q_pc[0] : 32'h0);
    check_output({tag, " deq_instr"}, deq_instr, (n > 0) ? q_instr[0] : 32'h0);
    check_output({tag, " imem_addr"}, imem_addr, m_pc);
  endtask

  // Drive inputs just after an edge, advance the model, then clock.
  task automatic apply_stimulus(input logic en, input logic rdy, input logic redir,
                                input logic [31:0] rpc);
    enable      = en;
    deq_ready   = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    model_step(en, rdy, redir, rpc);
    @(posedge Clk);
    #1;
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        valid;
    logic [2:0]  cnt;
    logic [31:0] pc;
    logic [31:0] addr;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic rst, input logic en, input logic rdy,
                              input logic redir, input logic [31:0] rpc,
                              input logic valid, input logic [2:0] cnt,
                              input logic [31:0] pc, input logic [31:0] addr);
    vec_t v;
    v.rst = rst; v.en = en; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.valid = valid; v.cnt = cnt; v.pc = pc; v.addr = addr;
    return v;
  endfunction

  initial begin
    logic [31:0] wrap_exp [4];
    wrap_exp[0] = 32'hFFFF_FFF8;
    wrap_exp[1] = 32'hFFFF_FFFC;
    wrap_exp[2] = 32'h0000_0000;
    wrap_exp[3] = 32'h0000_0004;

    // Sequential fetch, then backpressure to full and drain.
    vecs[0]  = mk(0, 1, 1, 0, 0,         1, 1, 32'h000, 32'h004);
    vecs[1]  = mk(0, 1, 1, 0, 0,         1, 1, 32'h004, 32'h008);
    vecs[2]  = mk(0, 1, 1, 0, 0,         1, 1, 32'h008, 32'h00C);
    vecs[3]  = mk(0, 1, 1, 0, 0,         1, 1, 32'h00C, 32'h010);
    vecs[4]  = mk(1, 1, 0, 0, 0,         1, 1, 32'h000, 32'h004);
    vecs[5]  = mk(0, 1, 0, 0, 0,         1, 2, 32'h000, 32'h008);
    vecs[6]  = mk(0, 1, 0, 0, 0,         1, 3, 32'h000, 32'h00C);
    vecs[7]  = mk(0, 1, 0, 0, 0,         1, 4, 32'h000, 32'h010);
    vecs[8]  = mk(0, 1, 0, 0, 0,         1, 4, 32'h000, 32'h010);
    vecs[9]  = mk(0, 1, 1, 0, 0,         1, 3, 32'h004, 32'h010);
    vecs[10] = mk(0, 1, 1, 0, 0,         1, 3, 32'h008, 32'h014);
    vecs[11] = mk(0, 1, 1, 0, 0,         1, 3, 32'h00C, 32'h018);
    vecs[12] = mk(0, 1, 1, 0, 0,         1, 3, 32'h010, 32'h01C);
    // Unaligned redirect with three entries queued.
    vecs[13] = mk(0, 1, 1, 1, 32'h103,   0, 0, 32'h000, 32'h100);
    vecs[14] = mk(0, 1, 0, 0, 0,         1, 1, 32'h100, 32'h104);
    vecs[15] = mk(0, 1, 0, 0, 0,         1, 2, 32'h100, 32'h108);
    vecs[16] = mk(0, 1, 0, 0, 0,         1, 3, 32'h100, 32'h10C);
    vecs[17] = mk(0, 1, 0, 0, 0,         1, 4, 32'h100, 32'h110);
    // Redirect on a full queue with enable and ready both high.
    vecs[18] = mk(0, 1, 1, 1, 32'h200,   0, 0, 32'h000, 32'h200);
    vecs[19] = mk(0, 0, 1, 0, 0,         0, 0, 32'h000, 32'h200);
    vecs[20] = mk(0, 1, 0, 0, 0,         1, 1, 32'h200, 32'h204);
    vecs[21] = mk(0, 1, 0, 0, 0,         1, 2, 32'h200, 32'h208);
    // Enable low: PC holds while the queue drains.
    vecs[22] = mk(0, 0, 1, 0, 0,         1, 1, 32'h204, 32'h208);
    vecs[23] = mk(0, 0, 1, 0, 0,         0, 0, 32'h000, 32'h208);
    vecs[24] = mk(0, 0, 1, 0, 0,         0, 0, 32'h000, 32'h208);

    reset = 1'b0;
    enable = 1'b0; deq_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    w_enable = 1'b0; w_deq_ready = 1'b0;
    model_reset(32'h0);
    repeat (2) @(posedge Clk);
    #1;
    check_output("reset count", 32'(count), 32'h0);
    check_output("reset valid", 32'(deq_valid), 32'h0);
    check_output("reset deq_pc", deq_pc, 32'h0);
    check_output("reset deq_instr", deq_instr, 32'h0);
    check_output("reset imem_addr", imem_addr, 32'h0);
    check_output("reset wrap imem_addr", w_imem_addr, 32'hFFFF_FFF8);
    reset = 1'b1;

    for (int i = 0; i < 25; i++) begin
      if (vecs[i].rst) begin
        reset = 1'b0;
        model_reset(32'h0);
        #1;
        reset = 1'b1;
      end
      apply_stimulus(vecs[i].en, vecs[i].rdy, vecs[i].redir, vecs[i].rpc);
      check_output($sformatf("vec%0d count", i), 32'(count), 32'(vecs[i].cnt));
      check_output($sformatf("vec%0d valid", i), 32'(deq_valid), 32'(vecs[i].valid));
      check_output($sformatf("vec%0d deq_pc", i), deq_pc, vecs[i].pc);
      check_output($sformatf("vec%0d deq_instr", i), deq_instr,
                   vecs[i].valid ? imem_fn(vecs[i].pc) : 32'h0);
      check_output($sformatf("vec%0d imem_addr", i), imem_addr, vecs[i].addr);
      compare_model($sformatf("vec%0d model", i));
    end

    // Asynchronous reset between edges with two entries queued.
    apply_stimulus(1, 0, 0, 0);
    apply_stimulus(1, 0, 0, 0);
    check_output("pre-async count", 32'(count), 32'h2);
    #3;
    reset = 1'b0;
    #1;
    check_output("async count", 32'(count), 32'h0);
    check_output("async valid", 32'(deq_valid), 32'h0);
    check_output("async imem_addr", imem_addr, 32'h0);
    check_output("async deq_pc", deq_pc, 32'h0);
    check_output("async deq_instr", deq_instr, 32'h0);
    #1;
    reset = 1'b1;
    model_reset(32'h0);

    // PC wrap-around on the high reset vector instance.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    w_enable = 1'b1;
    w_deq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      apply_stimulus(0, 0, 0, 0);
      check_output($sformatf("wrap%0d valid", k), 32'(w_deq_valid), 32'h1);
      check_output($sformatf("wrap%0d deq_pc", k), w_deq_pc, wrap_exp[k]);
      check_output($sformatf("wrap%0d deq_instr", k), w_deq_instr,
                   wrap_exp[k] ^ 32'h5A5A_0000);
    end
    w_enable = 1'b0;

    // Random traffic against the reference model.
    for (int r = 0; r < 400; r++) begin
      apply_stimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                     1'($urandom_range(0, 15) == 0), $urandom);
      compare_model($sformatf("rand%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
